// File: rtl/aes_batch_ctrl.sv
// rtl/aes_batch_ctrl.sv - multi-block AES job controller (ECB/CBC/CTR chaining, status, irq)
// Optional per-block WAIT watchdog is built when AES_BATCH_TIMEOUT_EN is defined.
module aes_batch_ctrl #(
  parameter int MAX_BLOCKS     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int AW = $clog2(MAX_BLOCKS),
  localparam int CW = $clog2(MAX_BLOCKS + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          abort,
  input  logic          enc_dec,
  input  logic [2:0]    mode,
  input  logic [CW-1:0] num_blocks,
  input  logic [127:0]  iv,
  output logic [AW-1:0] blk_rd_addr,
  input  logic [127:0]  blk_rd_data,
  output logic          out_wr_en,
  output logic [AW-1:0] out_wr_addr,
  output logic [127:0]  out_wr_data,
  output logic          aes_start,
  output logic [127:0]  aes_plaintext,
  output logic [127:0]  aes_iv,
  output logic [2:0]    aes_mode,
  output logic          aes_enc_dec,
  input  logic          aes_done,
  input  logic [127:0]  aes_result,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code,
  output logic [CW-1:0] blocks_done,
  output logic          irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam logic [CW-1:0] MAX_NB = CW'(MAX_BLOCKS);

  state_t        state_q, state_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [CW-1:0] blocks_done_q, blocks_done_d;
  logic          irq_q, irq_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] nb_q, nb_d;
  logic [127:0]  chain_q, chain_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [127:0]  pt_q, pt_d;
  logic [127:0]  aes_iv_q, aes_iv_d;
  logic [2:0]    mode_q, mode_d;
  logic          enc_dec_q, enc_dec_d;
  logic          aes_start_q, aes_start_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [127:0]  wr_data_q, wr_data_d;
`ifdef AES_BATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  logic       launch;
  logic       active;
  logic       err_go;
  logic [1:0] err_val;

  always_comb begin
    state_d       = state_q;
    start_d       = start;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;
    err_code_d    = err_code_q;
    blocks_done_d = blocks_done_q;
    irq_d         = 1'b0;
    idx_d         = idx_q;
    nb_d          = nb_q;
    chain_d       = chain_q;
    rd_addr_d     = rd_addr_q;
    pt_d          = pt_q;
    aes_iv_d      = aes_iv_q;
    mode_d        = mode_q;
    enc_dec_d     = enc_dec_q;
    aes_start_d   = 1'b0;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
`ifdef AES_BATCH_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif
    err_go        = 1'b0;
    err_val       = 2'd0;
    // abort outranks a simultaneous start edge
    launch = start && !start_q && !abort;
    active = (state_q == S_FETCH) || (state_q == S_LOAD) ||
             (state_q == S_WAIT)  || (state_q == S_WRITE);

    if (active && abort) begin
      err_go  = 1'b1;
      err_val = 2'd3;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (launch) begin
            done_d        = 1'b0;
            error_d       = 1'b0;
            err_code_d    = 2'd0;
            blocks_done_d = '0;
            mode_d        = mode;
            enc_dec_d     = enc_dec;
            nb_d          = num_blocks;
            chain_d       = iv;
            if (num_blocks == '0 || num_blocks > MAX_NB || mode > 3'd2) begin
              err_go  = 1'b1;
              err_val = 2'd1;
            end else begin
              idx_d     = '0;
              rd_addr_d = '0;
              busy_d    = 1'b1;
              state_d   = S_FETCH;
            end
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          pt_d        = blk_rd_data;
          aes_iv_d    = chain_q;
          aes_start_d = 1'b1;
`ifdef AES_BATCH_TIMEOUT_EN
          tmo_d       = '0;
`endif
          state_d     = S_WAIT;
        end
        S_WAIT: begin
          if (aes_done) begin
            wr_data_d = aes_result;
            wr_addr_d = idx_q;
            wr_en_d   = 1'b1;
            state_d   = S_WRITE;
            case (mode_q)
              3'd1:    chain_d = enc_dec_q ? aes_result : pt_q;
              3'd2:    chain_d = {chain_q[127:32], chain_q[31:0] + 32'd1};
              default: chain_d = chain_q;
            endcase
          end
`ifdef AES_BATCH_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_go  = 1'b1;
            err_val = 2'd2;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
`endif
        end
        S_WRITE: begin
          blocks_done_d = blocks_done_q + CW'(1);
          if (CW'(idx_q) == nb_q - CW'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            irq_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d     = idx_q + AW'(1);
            rd_addr_d = idx_q + AW'(1);
            state_d   = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (err_go) begin
      state_d    = S_ERROR;
      busy_d     = 1'b0;
      error_d    = 1'b1;
      err_code_d = err_val;
      irq_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= 2'd0;
      blocks_done_q <= '0;
      irq_q         <= 1'b0;
      idx_q         <= '0;
      nb_q          <= '0;
      chain_q       <= '0;
      rd_addr_q     <= '0;
      pt_q          <= '0;
      aes_iv_q      <= '0;
      mode_q        <= 3'd0;
      enc_dec_q     <= 1'b0;
      aes_start_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
`ifdef AES_BATCH_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      err_code_q    <= err_code_d;
      blocks_done_q <= blocks_done_d;
      irq_q         <= irq_d;
      idx_q         <= idx_d;
      nb_q          <= nb_d;
      chain_q       <= chain_d;
      rd_addr_q     <= rd_addr_d;
      pt_q          <= pt_d;
      aes_iv_q      <= aes_iv_d;
      mode_q        <= mode_d;
      enc_dec_q     <= enc_dec_d;
      aes_start_q   <= aes_start_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
`ifdef AES_BATCH_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  // The write strobe is registered but an abort in the WRITE cycle must still suppress it.
  assign out_wr_en     = wr_en_q && !abort;
  assign out_wr_addr   = wr_addr_q;
  assign out_wr_data   = wr_data_q;
  assign blk_rd_addr   = rd_addr_q;
  assign aes_start     = aes_start_q;
  assign aes_plaintext = pt_q;
  assign aes_iv        = aes_iv_q;
  assign aes_mode      = mode_q;
  assign aes_enc_dec   = enc_dec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign blocks_done   = blocks_done_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_aes_batch_ctrl.sv
// tb/tb_aes_batch_ctrl.sv - directed self-checking bench for aes_batch_ctrl with a stub core (L=2, result = input ^ 1)
module tb_aes_batch_ctrl;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b1;
  logic         abort = 1'b0;
  logic         enc_dec = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic [3:0]   num_blocks = 4'd0;
  logic [127:0] iv = '0;
  logic [2:0]   blk_rd_addr;
  logic [127:0] blk_rd_data = '0;
  logic         out_wr_en;
  logic [2:0]   out_wr_addr;
  logic [127:0] out_wr_data;
  logic         aes_start;
  logic [127:0] aes_plaintext;
  logic [127:0] aes_iv;
  logic [2:0]   aes_mode;
  logic         aes_enc_dec;
  logic         aes_done = 1'b0;
  logic [127:0] aes_result = '0;
  logic         busy, done, error;
  logic [1:0]   err_code;
  logic [3:0]   blocks_done;
  logic         irq;

  aes_batch_ctrl #(.MAX_BLOCKS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .enc_dec(enc_dec),
    .mode(mode), .num_blocks(num_blocks), .iv(iv), .blk_rd_addr(blk_rd_addr),
    .blk_rd_data(blk_rd_data), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
    .out_wr_data(out_wr_data), .aes_start(aes_start), .aes_plaintext(aes_plaintext),
    .aes_iv(aes_iv), .aes_mode(aes_mode), .aes_enc_dec(aes_enc_dec), .aes_done(aes_done),
    .aes_result(aes_result), .busy(busy), .done(done), .error(error), .err_code(err_code),
    .blocks_done(blocks_done), .irq(irq)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] M0 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] M1 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] M2 = 128'hdeadbeef_cafebabe_01234567_89abcdef;
  localparam logic [127:0] E0 = 128'h00112233_44556677_8899aabb_ccddeefe;
  localparam logic [127:0] E1 = 128'h0f0e0d0c_0b0a0908_07060504_03020101;
  localparam logic [127:0] E2 = 128'hdeadbeef_cafebabe_01234567_89abcdee;
  localparam logic [127:0] IVA = 128'ha5a5a5a5_5a5a5a5a_12345678_9abcdef0;
  localparam logic [127:0] IVC = 128'h11112222_33334444_55556666_ffffffff;
  localparam logic [127:0] IVW = 128'h11112222_33334444_55556666_00000000;

  logic [127:0] mem [0:7];
  logic         core_mute = 1'b0;
  logic [1:0]   pend = 2'd0;

  always @(posedge clk) blk_rd_data <= mem[blk_rd_addr];

  always @(posedge clk) begin
    aes_done <= 1'b0;
    if (!resetn) begin
      pend <= 2'd0;
    end else if (aes_start && !core_mute) begin
      pend <= 2'd1;
    end else if (pend == 2'd1) begin
      pend       <= 2'd0;
      aes_done   <= 1'b1;
      aes_result <= aes_plaintext ^ 128'h1;
    end
  end

  int           cyc = 0;
  int           t0 = 0;
  int           wr_count = 0, st_count = 0, irq_count = 0;
  int           wr_base = 0, st_base = 0, irq_base = 0;
  int           done_cyc = 0, err_cyc = 0;
  logic         done_prev = 1'b0, err_prev = 1'b0;
  logic [2:0]   wa_log [0:63];
  logic [127:0] wd_log [0:63];
  logic [127:0] iv_log [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_wr_en) begin
      wa_log[wr_count[5:0]] <= out_wr_addr;
      wd_log[wr_count[5:0]] <= out_wr_data;
      wr_count <= wr_count + 1;
    end
    if (aes_start) begin
      iv_log[st_count[5:0]] <= aes_iv;
      st_count <= st_count + 1;
    end
    if (irq) irq_count <= irq_count + 1;
    if (done && !done_prev) done_cyc <= cyc - t0;
    if (error && !err_prev) err_cyc <= cyc - t0;
    done_prev <= done;
    err_prev  <= error;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    wr_base  = wr_count;
    st_base  = st_count;
    irq_base = irq_count;
  endtask

  task automatic launch(input logic ed, input logic [2:0] md, input logic [3:0] nb,
                        input logic [127:0] v);
    @(posedge clk); #1;
    snap();
    enc_dec = ed; mode = md; num_blocks = nb; iv = v; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    int n;
    n = 0;
    tick();
    while (busy && n < limit) begin
      tick();
      n++;
    end
    check("batch_end", 128'(busy), 128'(0));
    repeat (4) tick();
  endtask

  initial begin
    int n;
    mem[0] = M0; mem[1] = M1; mem[2] = M2; mem[3] = 128'h3;
    mem[4] = 128'h4; mem[5] = 128'h5; mem[6] = 128'h6; mem[7] = 128'h7;

    repeat (3) @(posedge clk);
    tick();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_status", 128'({done, error, err_code, irq}), 128'(0));
    check("rst_blocks_done", 128'(blocks_done), 128'(0));
    check("rst_strobes", 128'({out_wr_en, aes_start}), 128'(0));
    check("rst_aes_iv", aes_iv, 128'(0));
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (4) tick();
    check("start_hi_rst_busy", 128'(busy), 128'(0));
    check("start_hi_rst_starts", 128'(st_count), 128'(0));
    start = 1'b0;

    launch(1'b1, 3'd0, 4'd3, IVA);
    wait_end(200);
    check("ecb_done_cycle", 128'(done_cyc), 128'(19));
    check("ecb_writes", 128'(wr_count - wr_base), 128'(3));
    check("ecb_addr0", 128'(wa_log[wr_base]), 128'(0));
    check("ecb_addr1", 128'(wa_log[wr_base + 1]), 128'(1));
    check("ecb_addr2", 128'(wa_log[wr_base + 2]), 128'(2));
    check("ecb_data0", wd_log[wr_base], E0);
    check("ecb_data1", wd_log[wr_base + 1], E1);
    check("ecb_data2", wd_log[wr_base + 2], E2);
    check("ecb_blocks_done", 128'(blocks_done), 128'(3));
    check("ecb_irq", 128'(irq_count - irq_base), 128'(1));
    check("ecb_done_err", 128'({done, error}), 128'(2'b10));
    check("ecb_iv2", iv_log[st_base + 2], IVA);

    launch(1'b1, 3'd1, 4'd2, IVA);
    wait_end(200);
    check("cbce_iv0", iv_log[st_base], IVA);
    check("cbce_iv1", iv_log[st_base + 1], E0);
    check("cbce_mode", 128'(aes_mode), 128'(1));

    launch(1'b0, 3'd1, 4'd2, IVA);
    wait_end(200);
    check("cbcd_iv1", iv_log[st_base + 1], M0);
    check("cbcd_dir", 128'(aes_enc_dec), 128'(0));
    check("cbcd_data1", wd_log[wr_base + 1], E1);

    launch(1'b1, 3'd2, 4'd2, IVC);
    wait_end(200);
    check("ctr_iv0", iv_log[st_base], IVC);
    check("ctr_iv1_wrap", iv_log[st_base + 1], IVW);

    launch(1'b1, 3'd0, 4'd0, IVA);
    wait_end(50);
    check("nb0_err", 128'({error, err_code}), 128'(3'b101));
    check("nb0_irq", 128'(irq_count - irq_base), 128'(1));
    check("nb0_nostart", 128'(st_count - st_base), 128'(0));
    check("nb0_nowrite", 128'(wr_count - wr_base), 128'(0));

    launch(1'b1, 3'd5, 4'd2, IVA);
    wait_end(50);
    check("mode5_err", 128'({error, err_code}), 128'(3'b101));
    check("mode5_irq", 128'(irq_count - irq_base), 128'(1));
    check("mode5_nostart", 128'(st_count - st_base), 128'(0));

    launch(1'b1, 3'd0, 4'd9, IVA);
    wait_end(50);
    check("nb9_err", 128'(err_code), 128'(1));

    launch(1'b1, 3'd0, 4'd4, IVA);
    n = 0;
    while ((st_count - st_base) < 2 && n < 100) begin
      tick();
      n++;
    end
    check("abw_blk1_started", 128'(st_count - st_base), 128'(2));
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (6) tick();
    check("abw_err", 128'({busy, error, err_code}), 128'(4'b0111));
    check("abw_writes", 128'(wr_count - wr_base), 128'(1));
    check("abw_addr0", 128'(wa_log[wr_base]), 128'(0));
    check("abw_blocks_done", 128'(blocks_done), 128'(1));
    check("abw_irq", 128'(irq_count - irq_base), 128'(1));

    launch(1'b1, 3'd0, 4'd1, IVA);
    wait_end(100);
    check("relaunch_status", 128'({done, error, err_code}), 128'(4'b1000));
    check("relaunch_writes", 128'(wr_count - wr_base), 128'(1));
    check("relaunch_data", wd_log[wr_base], E0);

    launch(1'b1, 3'd0, 4'd1, IVA);
    n = 0;
    while (!aes_done && n < 100) begin
      tick();
      n++;
    end
    check("abwr_done_seen", 128'(aes_done), 128'(1));
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (4) tick();
    check("abwr_nowrite", 128'(wr_count - wr_base), 128'(0));
    check("abwr_err", 128'(err_code), 128'(3));
    check("abwr_blocks_done", 128'(blocks_done), 128'(0));

    @(posedge clk); #1;
    snap();
    mode = 3'd0; num_blocks = 4'd1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (6) tick();
    check("abst_nolaunch", 128'(st_count - st_base), 128'(0));
    check("abst_status", 128'({busy, error, err_code}), 128'(4'b0111));

`ifdef AES_BATCH_TIMEOUT_EN
    core_mute = 1'b1;
    launch(1'b1, 3'd0, 4'd1, IVA);
    wait_end(100);
    check("tmo_err", 128'({error, err_code}), 128'(3'b110));
    check("tmo_cycle", 128'(err_cyc), 128'(19));
    check("tmo_nowrite", 128'(wr_count - wr_base), 128'(0));
    core_mute = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
